// File: rtl/window_fifo_pkg.sv
// -----------------------------------------------------------------------------
// window_fifo_pkg
// Shared types and helpers for the sliding-window input FIFO.
//   state_t       : controller state (IDLE / RUN)
//   window_cfg_t  : latched window configuration {kernel K, stride S, row_len L}
//   row_step_t    : result of one row step {last, adv}
//   cfg_legal()   : 1 <= K <= max_k, 1 <= S <= 3, L >= K
//   row_advance() : last = (c + S + K > L); adv = last ? L - c : S
//   window_need() : words that must be stored before a window may issue
// -----------------------------------------------------------------------------
package window_fifo_pkg;

  // o_almost_full asserts this many words below completely full.
  localparam int ALMOST_FULL_MARGIN = 3;

  // Internal width for row arithmetic; the top's COL_WIDTH must not exceed it.
  localparam int CFG_LEN_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0]           kernel;
    logic [1:0]           stride;
    logic [CFG_LEN_W-1:0] row_len;
  } window_cfg_t;

  typedef struct packed {
    logic                 last;
    logic [CFG_LEN_W-1:0] adv;
  } row_step_t;

  function automatic logic cfg_legal(input window_cfg_t cfg, input int unsigned max_k);
    logic k_ok;
    logic s_ok;
    logic l_ok;
    k_ok = (cfg.kernel != 3'd0) && (32'(cfg.kernel) <= max_k);
    s_ok = (cfg.stride != 2'd0);
    l_ok = (cfg.row_len >= CFG_LEN_W'(cfg.kernel));
    return k_ok && s_ok && l_ok;
  endfunction

  // A window is the last of its row when the following window would not fit.
  // The last window jumps the read pointer to the first word of the next row.
  function automatic row_step_t row_advance(
    input logic [CFG_LEN_W-1:0] col,
    input logic [1:0]           stride,
    input logic [2:0]           kernel,
    input logic [CFG_LEN_W-1:0] row_len
  );
    row_step_t          step;
    logic [CFG_LEN_W:0] reach;
    reach     = {1'b0, col} + (CFG_LEN_W+1)'(stride) + (CFG_LEN_W+1)'(kernel);
    step.last = (reach > {1'b0, row_len});
    step.adv  = step.last ? (row_len - col) : CFG_LEN_W'(stride);
    return step;
  endfunction

  // The window itself needs K words; the pointer jump needs adv words to be
  // present so that r_ptr never passes w_ptr.
  function automatic logic [CFG_LEN_W-1:0] window_need(
    input row_step_t  step,
    input logic [2:0] kernel
  );
    logic [CFG_LEN_W-1:0] k_ext;
    k_ext = CFG_LEN_W'(kernel);
    return (step.adv > k_ext) ? step.adv : k_ext;
  endfunction

endpackage

// File: rtl/window_fifo_mem.sv
// -----------------------------------------------------------------------------
// window_fifo_mem
// FIFO_DEPTH x DATA_WIDTH storage with one synchronous write port and
// MAX_READ_PORTS combinational read lanes. Lane i reads (i_rd_base + i)
// modulo FIFO_DEPTH, so a window may straddle the wrap point.
// Ports:
//   i_clock    : clock, rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write word
//   i_rd_base  : address of lane 0
//   o_rd_data  : MAX_READ_PORTS read lanes
// -----------------------------------------------------------------------------
module window_fifo_mem #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 32,
  parameter int MAX_READ_PORTS = 5,
  parameter int ADDR_WIDTH     = $clog2(FIFO_DEPTH)
) (
  input  logic                                     i_clock,
  input  logic                                     i_wr_en,
  input  logic [ADDR_WIDTH-1:0]                    i_wr_addr,
  input  logic [DATA_WIDTH-1:0]                    i_wr_data,
  input  logic [ADDR_WIDTH-1:0]                    i_rd_base,
  output logic [MAX_READ_PORTS-1:0][DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // NOTE: the storage array has no reset; a word is only ever read after it
  // has been written, so clearing it would buy nothing but reset fan-out.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Address addition is ADDR_WIDTH bits wide, so it wraps modulo FIFO_DEPTH.
  always_comb begin
    for (int i = 0; i < MAX_READ_PORTS; i++) begin
      o_rd_data[i] = mem_q[i_rd_base + ADDR_WIDTH'(i)];
    end
  end

endmodule

// File: rtl/window_input_fifo.sv
// -----------------------------------------------------------------------------
// window_input_fifo
// Buffers a row-major activation stream and emits K-wide sliding windows at a
// programmable stride S over rows of length L. The row-end pointer jump is
// derived from an internal column counter.
// Optional feature macro: WINDOW_FIFO_ROW_COUNT_EN adds o_row_count, the
// saturating number of accepted row-last windows.
// Ports:
//   i_clock, i_reset         : clock; asynchronous active-low reset
//   i_cfg_load               : pulse, latch i_cfg_kernel/stride/row_len
//   i_cfg_kernel/stride/row_len : window configuration K, S, L
//   i_flush                  : synchronous clear of contents, config kept
//   i_wvalid/o_wready/i_wdata: write handshake and data
//   o_rvalid/i_rready        : window handshake
//   o_rdata                  : window lanes, lane i = word at start + i
//   o_rlast                  : window is the last of its row
//   o_count                  : words stored
//   o_almost_full, o_empty   : occupancy flags
//   o_cfg_err                : last accepted cfg_load was illegal
// -----------------------------------------------------------------------------
module window_input_fifo
  import window_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 32,
  parameter int MAX_READ_PORTS = 5,
  parameter int COL_WIDTH      = 6,
  parameter int POINTER_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic                                     i_cfg_load,
  input  logic [2:0]                               i_cfg_kernel,
  input  logic [1:0]                               i_cfg_stride,
  input  logic [COL_WIDTH-1:0]                     i_cfg_row_len,
  input  logic                                     i_flush,
  input  logic                                     i_wvalid,
  output logic                                     o_wready,
  input  logic [DATA_WIDTH-1:0]                    i_wdata,
  output logic                                     o_rvalid,
  input  logic                                     i_rready,
  output logic [MAX_READ_PORTS-1:0][DATA_WIDTH-1:0] o_rdata,
  output logic                                     o_rlast,
  output logic [POINTER_WIDTH:0]                   o_count,
  output logic                                     o_almost_full,
  output logic                                     o_empty,
  output logic                                     o_cfg_err
`ifdef WINDOW_FIFO_ROW_COUNT_EN
  ,
  output logic [15:0]                              o_row_count
`endif
);

  localparam int PW = POINTER_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                                    state_q,   state_d;
  window_cfg_t                               cfg_q,     cfg_d;
  logic                                      cfg_err_q, cfg_err_d;
  logic [PW-1:0]                             w_ptr_q,   w_ptr_d;
  logic [PW-1:0]                             r_ptr_q,   r_ptr_d;
  logic [COL_WIDTH-1:0]                      col_q,     col_d;
  logic                                      rvalid_q,  rvalid_d;
  logic                                      rlast_q,   rlast_d;
  logic [MAX_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata_q,   rdata_d;

  // ---------------------------------------------------------------------------
  // Derived status
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 wready;
  logic                 wr_en;
  window_cfg_t          cfg_in;
  logic                 cfg_ok;
  logic                 cfg_accept;
  row_step_t            step;
  logic [CFG_LEN_W-1:0] need;
  logic                 issue;
  logic                 accept;
  logic [MAX_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_lanes;

  // Pointer difference wraps naturally thanks to the extra wrap bit.
  assign count  = w_ptr_q - r_ptr_q;
  assign full   = (count == PW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign wready = (state_q == RUN) && !full;
  assign wr_en  = i_wvalid && wready && !i_flush;

  assign cfg_in = '{kernel:  i_cfg_kernel,
                    stride:  i_cfg_stride,
                    row_len: CFG_LEN_W'(i_cfg_row_len)};
  assign cfg_ok = cfg_legal(cfg_in, MAX_READ_PORTS);

  // A reload while running is only honoured once the pipe is fully drained,
  // so a window can never be cut with the wrong geometry.
  assign cfg_accept = i_cfg_load && ((state_q == IDLE) || (empty && !rvalid_q));

  assign step   = row_advance(CFG_LEN_W'(col_q), cfg_q.stride, cfg_q.kernel, cfg_q.row_len);
  assign need   = window_need(step, cfg_q.kernel);
  assign accept = rvalid_q && i_rready;
  assign issue  = (state_q == RUN) && (!rvalid_q || i_rready) &&
                  (CFG_LEN_W'(count) >= need) && !i_flush;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  window_fifo_mem #(
    .DATA_WIDTH     (DATA_WIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .MAX_READ_PORTS (MAX_READ_PORTS),
    .ADDR_WIDTH     (POINTER_WIDTH)
  ) u_mem (
    .i_clock   (i_clock),
    .i_wr_en   (wr_en),
    .i_wr_addr (w_ptr_q[POINTER_WIDTH-1:0]),
    .i_wr_data (i_wdata),
    .i_rd_base (r_ptr_q[POINTER_WIDTH-1:0]),
    .o_rd_data (rd_lanes)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first,
    // so no path through this block can leave a variable unassigned (latch).
    state_d   = state_q;
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    col_d     = col_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;

    // Configuration. An accepted load never coincides with an issue: in RUN
    // it requires an empty FIFO, and an issue needs at least K >= 1 words.
    if (cfg_accept) begin
      col_d = '0;
      if (cfg_ok) begin
        state_d   = RUN;
        cfg_d     = cfg_in;
        cfg_err_d = 1'b0;
      end else begin
        state_d   = IDLE;
        cfg_err_d = 1'b1;
      end
    end

    if (wr_en) begin
      w_ptr_d = w_ptr_q + PW'(1);
    end

    if (issue) begin
      for (int i = 0; i < MAX_READ_PORTS; i++) begin
        rdata_d[i] = (i < int'(cfg_q.kernel)) ? rd_lanes[i] : '0;
      end
      rvalid_d = 1'b1;
      rlast_d  = step.last;
      r_ptr_d  = r_ptr_q + PW'(step.adv);
      col_d    = step.last ? '0 : COL_WIDTH'(CFG_LEN_W'(col_q) + CFG_LEN_W'(cfg_q.stride));
    end else if (accept) begin
      rvalid_d = 1'b0;
    end

    // Flush overrides any write or issue in the same cycle; config is kept.
    if (i_flush) begin
      w_ptr_d  = '0;
      r_ptr_d  = '0;
      col_d    = '0;
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      cfg_err_q <= 1'b0;
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      col_q     <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      col_q     <= col_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional row counter
  // ---------------------------------------------------------------------------
`ifdef WINDOW_FIFO_ROW_COUNT_EN
  logic [15:0] row_count_q, row_count_d;

  always_comb begin
    row_count_d = row_count_q;
    if (accept && rlast_q && (row_count_q != 16'hFFFF)) begin
      row_count_d = row_count_q + 16'd1;
    end
    if (i_flush || (cfg_accept && cfg_ok)) begin
      row_count_d = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      row_count_q <= '0;
    end else begin
      row_count_q <= row_count_d;
    end
  end

  assign o_row_count = row_count_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_wready      = wready;
  assign o_rvalid      = rvalid_q;
  assign o_rdata       = rdata_q;
  assign o_rlast       = rlast_q;
  assign o_count       = count;
  assign o_almost_full = (count >= PW'(FIFO_DEPTH - ALMOST_FULL_MARGIN));
  assign o_empty       = empty;
  assign o_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_window_input_fifo.sv
// -----------------------------------------------------------------------------
// tb_window_input_fifo
// Scoreboard bench: written words go into an absolute-index stream model; each
// window that the stream makes available is pushed as an expected item. A
// monitor pops and compares whenever the DUT presents a window.
// -----------------------------------------------------------------------------
module tb_window_input_fifo;

  localparam int DW   = 32;
  localparam int DEPTH = 32;
  localparam int MRP  = 5;
  localparam int CW   = 6;
  localparam int PW   = $clog2(DEPTH);

  logic                    i_clock = 1'b0;
  logic                    i_reset;
  logic                    i_cfg_load;
  logic [2:0]              i_cfg_kernel;
  logic [1:0]              i_cfg_stride;
  logic [CW-1:0]           i_cfg_row_len;
  logic                    i_flush;
  logic                    i_wvalid;
  logic                    o_wready;
  logic [DW-1:0]           i_wdata;
  logic                    o_rvalid;
  logic                    i_rready;
  logic [MRP-1:0][DW-1:0]  o_rdata;
  logic                    o_rlast;
  logic [PW:0]             o_count;
  logic                    o_almost_full;
  logic                    o_empty;
  logic                    o_cfg_err;
`ifdef WINDOW_FIFO_ROW_COUNT_EN
  logic [15:0]             o_row_count;
`endif

  window_input_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_READ_PORTS(MRP), .COL_WIDTH(CW)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_cfg_load    (i_cfg_load),
    .i_cfg_kernel  (i_cfg_kernel),
    .i_cfg_stride  (i_cfg_stride),
    .i_cfg_row_len (i_cfg_row_len),
    .i_flush       (i_flush),
    .i_wvalid      (i_wvalid),
    .o_wready      (o_wready),
    .i_wdata       (i_wdata),
    .o_rvalid      (o_rvalid),
    .i_rready      (i_rready),
    .o_rdata       (o_rdata),
    .o_rlast       (o_rlast),
    .o_count       (o_count),
    .o_almost_full (o_almost_full),
    .o_empty       (o_empty),
    .o_cfg_err     (o_cfg_err)
`ifdef WINDOW_FIFO_ROW_COUNT_EN
    ,
    .o_row_count   (o_row_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: absolute word stream and window geometry
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [MRP*DW-1:0] data;
    bit                last;
    int                next_start;
  } win_t;

  win_t          exp_q[$];
  logic [DW-1:0] m_words[$];
  int            m_k = 1, m_s = 1, m_l = 1;
  int            m_row = 0, m_c = 0;
  int            m_rows = 0;
  bit            m_run = 0, m_err = 0;
  int            n_windows = 0;
  int            rr_mode = 0;   // 0: always ready, 1: random, 2: never

  function automatic void model_clear();
    m_words.delete();
    exp_q.delete();
    m_row  = 0;
    m_c    = 0;
    m_rows = 0;
  endfunction

  // Push every window whose words (and row-end jump) are now all stored.
  function automatic void model_release();
    int   start, adv, need;
    bit   last;
    win_t w;
    while (1) begin
      last  = (m_c + m_s + m_k) > m_l;
      adv   = last ? (m_l - m_c) : m_s;
      need  = (adv > m_k) ? adv : m_k;
      start = m_row * m_l + m_c;
      if (m_words.size() < start + need) break;
      w.data = '0;
      for (int i = 0; i < m_k; i++) w.data[i*DW +: DW] = m_words[start + i];
      w.last       = last;
      w.next_start = start + adv;
      exp_q.push_back(w);
      if (last) begin
        m_row++;
        m_c = 0;
      end else begin
        m_c += m_s;
      end
    end
  endfunction

  // held=1: DUT holds exp_q[0] on its output and has issued nothing beyond it.
  function automatic int model_count(input bit held);
    if (held && exp_q.size() > 0) return m_words.size() - exp_q[0].next_start;
    return m_words.size() - (m_row * m_l + m_c);
  endfunction

  // ---------------------------------------------------------------------------
  // Consumer ready generator (sole driver of i_rready)
  // ---------------------------------------------------------------------------
  initial begin
    i_rready = 1'b1;
    forever begin
      @(posedge i_clock);
      #1;
      case (rr_mode)
        0:       i_rready = 1'b1;
        1:       i_rready = 1'($urandom_range(0, 1));
        default: i_rready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    win_t w;
    forever begin
      @(negedge i_clock);
      if (i_reset && o_rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", 1'b1, 1'b0);
        end else if (i_rready) begin
          w = exp_q.pop_front();
          check("window_data", o_rdata, w.data);
          check("window_last", o_rlast, w.last);
          n_windows++;
          if (w.last) m_rows++;
        end else begin
          check("held_data", o_rdata, exp_q[0].data);
          check("held_last", o_rlast, exp_q[0].last);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (all start and end at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic settle(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, output bit ok);
    i_wvalid = 1'b1;
    i_wdata  = d;
    @(negedge i_clock);
    ok = o_wready;
    @(posedge i_clock);
    #1;
    i_wvalid = 1'b0;
    if (ok) begin
      m_words.push_back(d);
      model_release();
    end
  endtask

  task automatic write_n(input int n, input bit counting, input int max_gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      write_word(counting ? DW'(m_words.size()) : $urandom, ok);
      if (max_gap > 0) settle($urandom_range(0, max_gap));
    end
  endtask

  task automatic load_cfg(input int k, input int s, input int l);
    bit legal, acc;
    legal = (k >= 1) && (k <= MRP) && (s >= 1) && (s <= 3) && (l >= k);
    acc   = !m_run || ((model_count(0) == 0) && (exp_q.size() == 0));
    i_cfg_kernel  = 3'(k);
    i_cfg_stride  = 2'(s);
    i_cfg_row_len = CW'(l);
    i_cfg_load    = 1'b1;
    @(posedge i_clock);
    #1;
    i_cfg_load = 1'b0;
    if (acc) begin
      m_err = !legal;
      m_run = legal;
      if (legal) begin
        m_k = k; m_s = s; m_l = l;
        model_clear();
      end
    end
    check("cfg_err", o_cfg_err, m_err);
    if (acc) check("cfg_wready", o_wready, m_run);
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    @(posedge i_clock);
    #1;
    i_flush = 1'b0;
    model_clear();
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc     = 0;
    rr_mode = 0;
    while ((exp_q.size() != 0 || o_rvalid) && cyc < 500) begin
      @(posedge i_clock);
      #1;
      cyc++;
    end
    check({tag, "_drain_in_time"}, cyc < 500, 1'b1);
    settle(3);
    check({tag, "_count"}, o_count, model_count(0));
`ifdef WINDOW_FIFO_ROW_COUNT_EN
    check({tag, "_row_count"}, o_row_count, m_rows);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int bad_cfg [4][3] = '{'{0, 1, 8}, '{6, 1, 8}, '{4, 1, 3}, '{3, 0, 8}};

  initial begin
    int  base, acc_words, k, s, l;
    bit  ok;

    i_reset = 1'b0; i_cfg_load = 1'b0; i_cfg_kernel = '0; i_cfg_stride = '0;
    i_cfg_row_len = '0; i_flush = 1'b0; i_wvalid = 1'b0; i_wdata = '0;
    #1;
    check("rst_wready", o_wready, 1'b0);
    check("rst_empty",  o_empty,  1'b1);
    check("rst_count",  o_count,  0);
    check("rst_rvalid", o_rvalid, 1'b0);
    check("rst_rlast",  o_rlast,  1'b0);
    check("rst_rdata",  o_rdata,  0);
    check("rst_cfg_err", o_cfg_err, 1'b0);
    settle(3);
    i_reset = 1'b1;
    settle(2);

    // K=3 S=1 L=8, words 0..15: starts 0..5 and 8..13, row jump adv=3.
    load_cfg(3, 1, 8);
    base = n_windows;
    write_n(16, 1, 0);
    drain("t1");
    check("t1_windows", n_windows - base, 12);

    // K=3 S=2 L=9, words 0..17: starts 0,2,4,6 | 9,11,13,15; lanes 3,4 zero.
    load_cfg(3, 2, 9);
    base = n_windows;
    write_n(18, 1, 0);
    drain("t2");
    check("t2_windows", n_windows - base, 8);

    // K=2 S=2 L=7: 6 words give windows 0,2; window 4 waits for word 6.
    load_cfg(2, 2, 7);
    base = n_windows;
    write_n(6, 1, 0);
    settle(6);
    check("t3_stall_windows", n_windows - base, 2);
    check("t3_stall_count", o_count, model_count(0));
    write_n(1, 1, 0);
    drain("t3");
    check("t3_windows", n_windows - base, 3);

    // Backpressure, then fill to full.
    load_cfg(3, 1, 8);
    rr_mode = 2;
    write_n(8, 0, 0);
    settle(10);
    check("bp_rvalid", o_rvalid, 1'b1);
    check("bp_count", o_count, model_count(1));
    acc_words = 8;
    for (int i = 0; i < 40 && acc_words < 33; i++) begin
      write_word($urandom, ok);
      if (ok) acc_words++;
      settle(2);
      check("fill_count", o_count, model_count(1));
      check("fill_almost_full", o_almost_full, model_count(1) >= DEPTH - 3);
    end
    write_word($urandom, ok);
    check("full_write_refused", ok, 1'b0);
    settle(1);
    check("full_count", o_count, DEPTH);
    check("full_wready", o_wready, 1'b0);
    drain("t4");
    // Not empty: this load must be ignored and the old geometry kept.
    load_cfg(2, 1, 10);
    do_flush();
    check("flush_count", o_count, 0);
    check("flush_empty", o_empty, 1'b1);
    check("flush_rvalid", o_rvalid, 1'b0);
    base = n_windows;
    write_n(8, 0, 0);
    drain("t4b");
    check("t4b_windows", n_windows - base, 6);

    // Illegal configurations, then a legal one.
    foreach (bad_cfg[i]) begin
      load_cfg(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2]);
      check("bad_cfg_wready", o_wready, 1'b0);
    end
    write_word(32'hDEAD_BEEF, ok);
    check("idle_write_refused", ok, 1'b0);
    load_cfg(3, 1, 8);
    check("good_cfg_wready", o_wready, 1'b1);

    // Randomized configurations, data, gaps and backpressure.
    for (int t = 0; t < 8; t++) begin
      do_flush();
      k = $urandom_range(1, MRP);
      s = $urandom_range(1, 3);
      l = $urandom_range(k, 20);
      load_cfg(k, s, l);
      rr_mode = 1;
      write_n($urandom_range(30, 70), 0, 2);
      drain("rand");
    end

    // Async reset mid-stream with 12 words stored.
    do_flush();
    load_cfg(5, 3, 40);
    rr_mode = 2;
    write_n(15, 0, 0);
    settle(3);
    check("pre_reset_count", o_count, model_count(1));
    @(posedge i_clock);
    #3;
    i_reset = 1'b0;
    #1;
    check("arst_count",   o_count,   0);
    check("arst_empty",   o_empty,   1'b1);
    check("arst_rvalid",  o_rvalid,  1'b0);
    check("arst_rlast",   o_rlast,   1'b0);
    check("arst_rdata",   o_rdata,   0);
    check("arst_wready",  o_wready,  1'b0);
    check("arst_cfg_err", o_cfg_err, 1'b0);
    m_run = 0;
    m_err = 0;
    model_clear();
    rr_mode = 0;
    settle(2);
    i_reset = 1'b1;
    settle(3);
    check("post_reset_wready", o_wready, 1'b0);
    write_word(32'h1234_5678, ok);
    check("post_reset_write_refused", ok, 1'b0);
    load_cfg(3, 1, 8);
    base = n_windows;
    write_n(8, 1, 0);
    drain("t7");
    check("t7_windows", n_windows - base, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
